kypd_emulator: RTL and testbench
================================

Name: kypd_emulator

Overview:
- Synthesizable 4x4 keypad responder: the "key side" of the PmodKYPD row/column scan protocol.
- Accepts a key code over a valid/ready handshake and presses that key electrically. It drives the active-low row lines in response to the scanner's active-low column drive.
- Models contact bounce on press and release, a hold time and an inter-key gap.
- Used for loopback bring-up and regression of the keypad decoder, debounce and pulse path without a physical keypad.

Parameters:
- BOUNCE_PERIOD, 1000: cycles per bounce segment; must be >= 1.
- BOUNCE_TOGGLES, 6: contact transitions per bounce phase; must be even; 0 disables bounce.
- HOLD_CYCLES, 5_000_000: stable-closed cycles (100 ms at 50 MHz); must be >= 1.
- GAP_CYCLES, 2_500_000: stable-open cycles after release before done; must be >= 1.

Ports:
- clk  input  1  system clock (clk_wiz output domain).
- rst  input  1  synchronous reset, active-high.
- key_code  input  4  hex key to press; sampled on accept.
- key_valid  input  1  press request.
- key_ready  output  1  high only in IDLE and not in reset.
- col_n  input  4  column drive from the scanner, active-low; col_n[c] is column c, with c=0 the leftmost.
- row_n  output  4  row sense lines, active-low; row_n[r] is row r, with r=0 the top.
- pressed  output  1  current modelled contact state; 1 means closed.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of GAP.

Behaviour:
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Row output (combinational from registered state):
  - row_n[r_key] = col_n[c_key] when pressed=1.
  - Every other row bit = 1.
  - All bits = 1 when pressed=0.
  - No ghosting; exactly one key is modelled.
- Reset values: state IDLE, key_ready=0 (during rst), busy=0, done=0, pressed=0, row_n=4'hF, counters 0. In the first cycle after rst deasserts, key_ready=1.
- Accept: at a rising edge with key_valid & key_ready, latch key_code and leave IDLE. The next cycle has busy=1 and key_ready=0.
- States and transitions:
  - IDLE: pressed=0. Goes to BOUNCE_IN on accept, or to HOLD if BOUNCE_TOGGLES=0.
  - BOUNCE_IN: BOUNCE_TOGGLES segments of BOUNCE_PERIOD cycles. pressed alternates 1,0,1,0,... starting at 1. Then goes to HOLD.
  - HOLD: pressed=1 for HOLD_CYCLES. Then goes to BOUNCE_OUT, or to GAP if BOUNCE_TOGGLES=0.
  - BOUNCE_OUT: BOUNCE_TOGGLES segments. pressed alternates 0,1,0,1,... starting at 0. Then goes to GAP.
  - GAP: pressed=0 for GAP_CYCLES. done=1 in its final cycle, then goes to IDLE.
- Busy duration: exactly 2*BOUNCE_TOGGLES*BOUNCE_PERIOD + HOLD_CYCLES + GAP_CYCLES cycles.
- Handshake and boundary rules:
  - key_valid while busy is ignored; no queuing.
  - The earliest next accept is the cycle after done.
  - key_code changes while busy have no effect.
- Counters: a single down-counter sized $clog2 of the max phase length plus 1, and a toggle counter sized $clog2(BOUNCE_TOGGLES+1). A terminal count reloads for the next segment or phase. No wrap-around reaches the outputs.
- Reset mid-operation: the state returns to IDLE at the same edge, row_n=4'hF and pressed=0 from the next cycle, and no done pulse is emitted.
- Static elaboration assertions reject: odd BOUNCE_TOGGLES, or any period, hold or gap parameter equal to 0.

Decomposition:
- kypd_pkg:
  - state enum (IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP).
  - key_pos_t struct {row[1:0], col[1:0]}.
  - function key_to_pos(code) implementing the map above.
- No sub-module. Counter and FSM stay in one module (about 150 lines); the map lives in the package so the scanner side can share it.

Test Plan:
Bench parameters: BOUNCE_PERIOD=4, BOUNCE_TOGGLES=4, HOLD_CYCLES=20, GAP_CYCLES=10.
1. Reset: hold rst 3 cycles -> row_n=4'hF, busy=0, done=0, key_ready=0. The cycle after release, key_ready=1.
2. Press key 5 (r1,c1):
   - pressed trace after accept is 1x4, 0x4, 1x4, 0x4, then 1x20 (HOLD).
   - During HOLD, col_n=4'b1101 -> row_n=4'b1101; col_n=4'b1110 -> row_n=4'hF.
3. Timing: accept at edge k -> busy high for cycles k+1..k+62. done high only in cycle k+62; key_ready=1 at k+63. Release trace is 0x4, 1x4, 0x4, 1x4, then 0x10.
4. key_valid held high with key_code=9 during a key-5 press -> not accepted; exactly one done, and 9 is accepted at k+63.
5. Map corners: key A (r0,c3) with col_n=4'b0111 -> row_n=4'b1110. Key 0 (r3,c0) with col_n=4'b1110 -> row_n=4'b0111. Key D (r3,c3) with col_n=4'b0111 -> row_n=4'b0111.
6. rst asserted in HOLD cycle 10 -> next cycle row_n=4'hF, pressed=0, busy=0, and no done pulse ever.

Source files
------------

// File: rtl/kypd_pkg.sv
// Shared definitions for the PmodKYPD key-side emulator: FSM states and the
// hex-code to row/column map, kept here so the scanner side can reuse it.
package kypd_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } kypd_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Row 0 is the top, column 0 the leftmost.
  function automatic key_pos_t key_to_pos(input logic [3:0] code);
    key_pos_t pos;
    case (code)
      4'h1: pos = '{row: 2'd0, col: 2'd0};
      4'h2: pos = '{row: 2'd0, col: 2'd1};
      4'h3: pos = '{row: 2'd0, col: 2'd2};
      4'hA: pos = '{row: 2'd0, col: 2'd3};
      4'h4: pos = '{row: 2'd1, col: 2'd0};
      4'h5: pos = '{row: 2'd1, col: 2'd1};
      4'h6: pos = '{row: 2'd1, col: 2'd2};
      4'hB: pos = '{row: 2'd1, col: 2'd3};
      4'h7: pos = '{row: 2'd2, col: 2'd0};
      4'h8: pos = '{row: 2'd2, col: 2'd1};
      4'h9: pos = '{row: 2'd2, col: 2'd2};
      4'hC: pos = '{row: 2'd2, col: 2'd3};
      4'h0: pos = '{row: 2'd3, col: 2'd0};
      4'hF: pos = '{row: 2'd3, col: 2'd1};
      4'hE: pos = '{row: 2'd3, col: 2'd2};
      default: pos = '{row: 2'd3, col: 2'd3};
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/kypd_emulator.sv
// Key side of the 4x4 row/column scan: presses one latched key with modelled
// contact bounce, hold and inter-key gap, answering the scanner's column drive.
module kypd_emulator #(
  parameter int BOUNCE_PERIOD  = 1000,
  parameter int BOUNCE_TOGGLES = 6,
  parameter int HOLD_CYCLES    = 5_000_000,
  parameter int GAP_CYCLES     = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       pressed,
  output logic       busy,
  output logic       done
);
  import kypd_pkg::*;

  localparam int MAX_AB  = (BOUNCE_PERIOD > HOLD_CYCLES) ? BOUNCE_PERIOD : HOLD_CYCLES;
  localparam int MAX_LEN = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam int TW      = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;

  localparam logic [CW-1:0] PERIOD_LOAD = CW'(BOUNCE_PERIOD - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TOG_LAST    = TW'((BOUNCE_TOGGLES > 0) ? BOUNCE_TOGGLES - 1 : 0);
  localparam bit            NO_BOUNCE   = (BOUNCE_TOGGLES == 0);

  if (BOUNCE_TOGGLES % 2 != 0 || BOUNCE_TOGGLES < 0) begin : g_bad_toggles
    $error("kypd_emulator: BOUNCE_TOGGLES must be even and non-negative");
  end
  if (BOUNCE_PERIOD < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_lengths
    $error("kypd_emulator: BOUNCE_PERIOD, HOLD_CYCLES and GAP_CYCLES must be >= 1");
  end

  kypd_state_t   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [TW-1:0] tog_reg, tog_next;
  logic [3:0]    key_reg, key_next;
  key_pos_t      pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tog_reg   <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tog_reg   <= tog_next;
      key_reg   <= key_next;
    end
  end

  // Each phase loads the down-counter with its length minus one; the zero
  // count either reloads the next bounce segment or moves to the next phase.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tog_next   = tog_reg;
    key_next   = key_reg;
    case (state_reg)
      IDLE: begin
        if (key_valid) begin
          key_next = key_code;
          tog_next = '0;
          if (NO_BOUNCE) begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = BOUNCE_IN;
            cnt_next   = PERIOD_LOAD;
          end
        end
      end
      BOUNCE_IN, BOUNCE_OUT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (tog_reg != TOG_LAST) begin
          tog_next = tog_reg + TW'(1);
          cnt_next = PERIOD_LOAD;
        end else begin
          tog_next = '0;
          if (state_reg == BOUNCE_IN) begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
          end else begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end
        end
      end
      HOLD: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else if (NO_BOUNCE) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          state_next = BOUNCE_OUT;
          cnt_next   = PERIOD_LOAD;
          tog_next   = '0;
        end
      end
      GAP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pressed   = 1'b0;
    busy      = (state_reg != IDLE);
    key_ready = (state_reg == IDLE) && !rst;
    done      = (state_reg == GAP) && (cnt_reg == '0) && !rst;
    case (state_reg)
      BOUNCE_IN:  pressed = ~tog_reg[0];
      HOLD:       pressed = 1'b1;
      BOUNCE_OUT: pressed = tog_reg[0];
      default:    pressed = 1'b0;
    endcase
  end

  assign pos = key_to_pos(key_reg);

  // Only the latched key's row follows its column; all other rows stay open.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_n[gi] = (pressed && (pos.row == 2'(gi))) ? col_n[pos.col] : 1'b1;
  end

endmodule

// File: tb/tb_kypd_emulator.sv
// Directed bench for kypd_emulator with short bounce/hold/gap timings.
module tb_kypd_emulator;

  localparam int BP = 4;
  localparam int BT = 4;
  localparam int HC = 20;
  localparam int GC = 10;
  localparam int BUSY_LEN = 2 * BT * BP + HC + GC;  // 62

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       pressed;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  kypd_emulator #(
    .BOUNCE_PERIOD (BP),
    .BOUNCE_TOGGLES(BT),
    .HOLD_CYCLES   (HC),
    .GAP_CYCLES    (GC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .col_n    (col_n),
    .row_n    (row_n),
    .pressed  (pressed),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived pressed trace for busy cycle i (1..62).
  function automatic logic exp_pressed(input int i);
    if (i >= 1 && i <= 16) return (((i - 1) / 4) % 2) == 0;
    if (i >= 17 && i <= 36) return 1'b1;
    if (i >= 37 && i <= 52) return (((i - 37) / 4) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic accept(input logic [3:0] code);
    key_code  = code;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!key_ready && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (!key_ready) begin
      fails++;
      $display("FAIL wait_idle: key_ready=%0b after %0d cycles, required 1", key_ready, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if (row_n !== 4'hF || busy !== 1'b0 || done !== 1'b0 || key_ready !== 1'b0 || pressed !== 1'b0) begin
      fails++;
      $display("FAIL reset: row_n=%h busy=%b done=%b key_ready=%b pressed=%b, required F 0 0 0 0",
               row_n, busy, done, key_ready, pressed);
    end else $display("[TB] reset ok");
    rst = 1'b0;
    tick();
    tests++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: key_ready=%b busy=%b, required 1 0", key_ready, busy);
    end else $display("[TB] reset release ok");
  endtask

  // Key 5 press with full cycle-by-cycle timing of busy/done/ready/pressed/row_n.
  task automatic test_press_timing();
    int bad = 0;
    logic [3:0] exp_row;
    col_n = 4'b1101;
    accept(4'h5);
    for (int i = 1; i <= BUSY_LEN + 1; i++) begin
      exp_row = exp_pressed(i) ? 4'b1101 : 4'hF;
      tests++;
      if (busy !== (i <= BUSY_LEN) || done !== (i == BUSY_LEN) || key_ready !== (i == BUSY_LEN + 1) ||
          pressed !== exp_pressed(i) || row_n !== exp_row) begin
        fails++;
        bad++;
        $display("FAIL press_timing cycle %0d: busy=%b done=%b ready=%b pressed=%b row_n=%b, required %b %b %b %b %b",
                 i, busy, done, key_ready, pressed, row_n, (i <= BUSY_LEN), (i == BUSY_LEN),
                 (i == BUSY_LEN + 1), exp_pressed(i), exp_row);
      end
      if (i == 25) begin
        col_n = 4'b1110;
        #1;
        tests++;
        if (row_n !== 4'hF) begin
          fails++;
          bad++;
          $display("FAIL hold_other_col: row_n=%b, required 1111", row_n);
        end
        col_n = 4'b1101;
      end
      if (i <= BUSY_LEN) tick();
    end
    $display("[TB] press key 5 timing: %0d errors", bad);
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    col_n = 4'b1101;
    accept(4'h5);
    key_code  = 4'h9;
    key_valid = 1'b1;
    tests++;
    if (row_n !== 4'b1101) begin
      fails++;
      $display("FAIL ignore_code_change: row_n=%b, required 1101", row_n);
    end
    for (int i = 1; i <= BUSY_LEN; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    tests++;
    if (dones != 1 || key_ready !== 1'b1) begin
      fails++;
      $display("FAIL busy_ignore: dones=%0d key_ready=%b, required 1 1", dones, key_ready);
    end
    col_n = 4'b1011;
    tick();
    key_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || pressed !== 1'b1 || row_n !== 4'b1011) begin
      fails++;
      $display("FAIL accept_after_done: busy=%b pressed=%b row_n=%b, required 1 1 1011", busy, pressed, row_n);
    end else $display("[TB] key 9 accepted at k+63");
    wait_idle();
  endtask

  task automatic test_map_corners();
    logic [3:0] codes [3] = '{4'hA, 4'h0, 4'hD};
    logic [3:0] cols  [3] = '{4'b0111, 4'b1110, 4'b0111};
    logic [3:0] exps  [3] = '{4'b1110, 4'b0111, 4'b0111};
    for (int t = 0; t < 3; t++) begin
      col_n = 4'hF;
      accept(codes[t]);
      col_n = cols[t];
      #1;
      tests++;
      if (row_n !== exps[t]) begin
        fails++;
        $display("FAIL map_%h: row_n=%b, required %b", codes[t], row_n, exps[t]);
      end else $display("[TB] map key %h col_n=%b -> row_n=%b", codes[t], cols[t], row_n);
      wait_idle();
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    col_n = 4'b1101;
    accept(4'h5);
    repeat (25) tick();  // now in busy cycle 26 = HOLD cycle 10
    tests++;
    if (pressed !== 1'b1 || row_n !== 4'b1101) begin
      fails++;
      $display("FAIL reset_mid_pre: pressed=%b row_n=%b, required 1 1101", pressed, row_n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (row_n !== 4'hF || pressed !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: row_n=%b pressed=%b busy=%b, required 1111 0 0", row_n, pressed, busy);
    end
    for (int i = 0; i < 80; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL reset_mid_done: dones=%0d, required 0", dones);
    end else $display("[TB] mid-press reset ok");
  endtask

  initial begin
    rst       = 1'b1;
    key_code  = 4'h0;
    key_valid = 1'b0;
    col_n     = 4'hF;
    test_reset();
    test_press_timing();
    test_busy_ignore();
    test_map_corners();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
